// File: rtl/bw_mul_pipe_stream.sv
// Baugh-Wooley array multiplier on (WIDTH+1)-bit sign/zero-extended operands with
// STAGES carry-save cuts, an input and an output register, and a stall-all valid/ready flow.
module bw_mul_pipe_stream #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_signed
);

  localparam int N1 = WIDTH + 1;

  // First array row handled by segment k; segment STAGES ends at row N1.
  function automatic int cut_row(input int k);
    return (k * N1) / (STAGES + 1);
  endfunction

  // One carry-save row: returns {next sum, next carry, finished low product bit}.
  function automatic logic [2*N1:0] row_step(
    input logic [N1-1:0] s,
    input logic [N1-1:0] c,
    input logic [N1-1:0] x,
    input logic          yb,
    input int            row
  );
    logic [N1-1:0] pp;
    logic [N1-1:0] fs;
    logic [N1-1:0] fc;
    for (int j = 0; j < N1; j++) begin
      pp[j] = (x[j] & yb) ^ ((row == N1 - 1) != (j == N1 - 1));
      fs[j] = s[j] ^ c[j] ^ pp[j];
      fc[j] = (s[j] & c[j]) | (s[j] & pp[j]) | (c[j] & pp[j]);
    end
    return {1'b0, fs[N1-1:1], fc, fs[0]};
  endfunction

  function automatic logic [N1-1:0] ripple_add(
    input logic [N1-1:0] a,
    input logic [N1-1:0] b,
    input logic          cin
  );
    logic          cy;
    logic [N1-1:0] sum;
    cy = cin;
    for (int j = 0; j < N1; j++) begin
      sum[j] = a[j] ^ b[j] ^ cy;
      cy     = (a[j] & b[j]) | (a[j] & cy) | (b[j] & cy);
    end
    return sum;
  endfunction

  // Stage 0 is the input register, stages 1..STAGES are the array cuts.
  logic [STAGES:0]         v_q,  v_d;
  logic [STAGES:0]         m_q,  m_d;
  logic [STAGES:0][N1-1:0] x_q,  x_d;
  logic [STAGES:0][N1-1:0] y_q,  y_d;
  logic [STAGES:0][N1-1:0] s_q,  s_d;
  logic [STAGES:0][N1-1:0] c_q,  c_d;
  logic [STAGES:0][N1-1:0] lo_q, lo_d;

  logic               out_valid_q,  out_valid_d;
  logic               out_signed_q, out_signed_d;
  logic [2*WIDTH-1:0] out_p_q,      out_p_d;

  logic                    en_s;
  logic [STAGES:0][N1-1:0] seg_s;
  logic [STAGES:0][N1-1:0] seg_c;
  logic [STAGES:0][N1-1:0] seg_lo;
  logic [2*N1:0]           step_s;
  logic                    in_seg_s;
  logic [N1-1:0]           hi_s;
  logic [2*N1-1:0]         prod_s;

  assign en_s     = ~out_valid_q | out_ready;
  assign in_ready = en_s;

  // Segment k advances the carry-save state of stage k through its share of rows.
  always_comb begin
    seg_s    = s_q;
    seg_c    = c_q;
    seg_lo   = lo_q;
    step_s   = '0;
    in_seg_s = 1'b0;
    for (int k = 0; k <= STAGES; k++) begin
      for (int r = 0; r < N1; r++) begin
        in_seg_s     = (r >= cut_row(k)) && (r < cut_row(k + 1));
        step_s       = row_step(seg_s[k], seg_c[k], x_q[k], y_q[k][r], r);
        seg_s[k]     = in_seg_s ? step_s[2*N1:N1+1] : seg_s[k];
        seg_c[k]     = in_seg_s ? step_s[N1:1]      : seg_c[k];
        seg_lo[k][r] = in_seg_s ? step_s[0]         : seg_lo[k][r];
      end
    end
  end

  // Carry-in of 1 supplies the 2^(WIDTH+1) Baugh-Wooley correction term.
  assign hi_s   = ripple_add(seg_s[STAGES], seg_c[STAGES], 1'b1);
  assign prod_s = {hi_s, seg_lo[STAGES]};

  // Next-state: operands extend into stage 0, each cut takes the previous segment's result.
  always_comb begin
    v_d  = v_q;
    m_d  = m_q;
    x_d  = x_q;
    y_d  = y_q;
    s_d  = s_q;
    c_d  = c_q;
    lo_d = lo_q;

    v_d[0]  = in_valid;
    m_d[0]  = in_signed;
    x_d[0]  = in_signed ? {in_x[WIDTH-1], in_x} : {1'b0, in_x};
    y_d[0]  = in_signed ? {in_y[WIDTH-1], in_y} : {1'b0, in_y};
    s_d[0]  = '0;
    c_d[0]  = '0;
    lo_d[0] = '0;

    for (int k = 1; k <= STAGES; k++) begin
      v_d[k]  = v_q[k-1];
      m_d[k]  = m_q[k-1];
      x_d[k]  = x_q[k-1];
      y_d[k]  = y_q[k-1];
      s_d[k]  = seg_s[k-1];
      c_d[k]  = seg_c[k-1];
      lo_d[k] = seg_lo[k-1];
    end

    out_valid_d  = v_q[STAGES];
    out_signed_d = m_q[STAGES];
    out_p_d      = prod_s[2*WIDTH-1:0];
  end

  // Pipeline registers: every stage holds together whenever the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q          <= '0;
      m_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      s_q          <= '0;
      c_q          <= '0;
      lo_q         <= '0;
      out_valid_q  <= 1'b0;
      out_signed_q <= 1'b0;
      out_p_q      <= '0;
    end else if (en_s) begin
      v_q          <= v_d;
      m_q          <= m_d;
      x_q          <= x_d;
      y_q          <= y_d;
      s_q          <= s_d;
      c_q          <= c_d;
      lo_q         <= lo_d;
      out_valid_q  <= out_valid_d;
      out_signed_q <= out_signed_d;
      out_p_q      <= out_p_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_signed = out_signed_q;
  assign out_p      = out_p_q;

endmodule

// File: tb/tb_bw_mul_pipe_stream.sv
// Directed bench for bw_mul_pipe_stream: a WIDTH=8/STAGES=2 instance plus
// STAGES=0 and STAGES=7 instances for the latency and product sweep.
module tb_bw_mul_pipe_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_signed;
  logic [7:0]  in_x, in_y;
  logic [15:0] out_p;

  logic        sw_valid, sw_ready, sw0_signed, sw7_signed;
  logic [7:0]  sw_x, sw_y;
  logic        s0_in_ready, s0_out_valid, s0_out_signed;
  logic        s7_in_ready, s7_out_valid, s7_out_signed;
  logic [15:0] s0_out_p, s7_out_p;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] q0[$];
  logic [16:0] q7[$];

  bw_mul_pipe_stream #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_signed(out_signed));

  bw_mul_pipe_stream #(.WIDTH(8), .STAGES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s0_in_ready),
    .in_signed(sw0_signed), .in_x(sw_x), .in_y(sw_y), .out_valid(s0_out_valid),
    .out_ready(sw_ready), .out_p(s0_out_p), .out_signed(s0_out_signed));

  bw_mul_pipe_stream #(.WIDTH(8), .STAGES(7)) u_s7 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s7_in_ready),
    .in_signed(sw7_signed), .in_x(sw_x), .in_y(sw_y), .out_valid(s7_out_valid),
    .out_ready(sw_ready), .out_p(s7_out_p), .out_signed(s7_out_signed));

  // Reference product: extend to 16 bits per mode, multiply modulo 2^16.
  function automatic logic [15:0] gold(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] xe;
    logic [15:0] ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_x = 8'h00; in_y = 8'h00;
    out_ready = 1'b1; sw_valid = 1'b0; sw_ready = 1'b1; sw0_signed = 1'b0;
    sw7_signed = 1'b0; sw_x = 8'h00; sw_y = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_p !== 16'h0000 || out_signed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b p=%h signed=%b, want 0 0000 0", out_valid, out_p, out_signed);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_most_negative();
    int lat;
    lat = 0;
    in_valid = 1'b1; in_signed = 1'b1; in_x = 8'h80; in_y = 8'h80; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL mostneg_latency: got %0d, want 4", lat);
    end
    checks++;
    if (out_p !== 16'h4000 || out_signed !== 1'b1) begin
      errors++;
      $display("FAIL mostneg_product: got %h/%b, want 4000/1", out_p, out_signed);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mostneg_single: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    in_valid = 1'b1; in_signed = 1'b0; in_x = 8'hFF; in_y = 8'hFF;
    @(posedge clk); #1;
    in_signed = 1'b1; in_x = 8'hFF; in_y = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen !== 1 || out_p !== 16'hFE01 || out_signed !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b p=%h signed=%b, want 1 fe01 0", out_valid, out_p, out_signed);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_p !== 16'hFFFF || out_signed !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b p=%h signed=%b, want 1 ffff 1", out_valid, out_p, out_signed);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stream();
    logic [16:0] beats[16];
    int bi, got, last, gaps;
    bi = 0; got = 0; last = -1; gaps = 0;
    for (int i = 0; i < 16; i++) begin
      beats[i] = {i[0] ^ 1'($urandom_range(0, 1)), 16'($urandom)};
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = (bi < 16);
      if (bi < 16) {in_signed, in_x, in_y} = beats[bi];
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %h with nothing outstanding", out_p);
        end else begin
          if ({out_signed, out_p} !== exp_q[0]) begin
            errors++;
            $display("FAIL stream_result: got %h, want %h", {out_signed, out_p}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (last >= 0 && cyc != last + 1) gaps++;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back({in_signed, gold(in_x, in_y, in_signed)});
        bi++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d results (%0d pending), want 16", got, exp_q.size());
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL stream_throughput: got %0d gaps, want 0", gaps);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] xs[8];
    logic [7:0] ys[8];
    int bi, got, stalls;
    xs = '{8'h7F, 8'h80, 8'h12, 8'hFE, 8'h00, 8'hC3, 8'h55, 8'h01};
    ys = '{8'h7F, 8'h7F, 8'h34, 8'hFE, 8'h99, 8'h3C, 8'hAA, 8'h80};
    bi = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (bi < 8);
      if (bi < 8) begin
        in_x = xs[bi]; in_y = ys[bi]; in_signed = bi[0];
      end
      @(negedge clk);
      if (out_valid === 1'b1 && !out_ready) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0 || exp_q.size() == 0 || {out_signed, out_p} !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_hold: got in_ready=%b out=%h, want 0 and frozen head", in_ready, {out_signed, out_p});
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: got %h with nothing outstanding", out_p);
        end else begin
          if ({out_signed, out_p} !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_result: got %h, want %h", {out_signed, out_p}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back({in_signed, gold(in_x, in_y, in_signed)});
        bi++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 8 || stalls !== 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d results %0d stall cycles, want 8 and 5", got, stalls);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b1;
    in_x = 8'h81; in_y = 8'h02;
    @(posedge clk); #1;
    in_x = 8'h11; in_y = 8'h22;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_p !== 16'hFF02 || out_signed !== 1'b1) begin
      errors++;
      $display("FAIL midflight_head: got valid=%b p=%h signed=%b, want 1 ff02 1", out_valid, out_p, out_signed);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 16'h0000 || out_signed !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: got valid=%b p=%h signed=%b, want 0 0000 0", out_valid, out_p, out_signed);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_stale: got %0d stale cycles in_ready=%b, want 0 and 1", stale, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stage_sweep();
    int lat0, lat7;
    logic m;
    lat0 = 0; lat7 = 0;
    sw_ready = 1'b1; sw_valid = 1'b1; sw0_signed = 1'b1; sw7_signed = 1'b1;
    sw_x = 8'h03; sw_y = 8'hFB;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat0 == 0 && s0_out_valid === 1'b1) lat0 = i;
      if (lat7 == 0 && s7_out_valid === 1'b1) lat7 = i;
    end
    checks++;
    if (lat0 !== 2) begin
      errors++;
      $display("FAIL s0_latency: got %0d, want 2", lat0);
    end
    checks++;
    if (lat7 !== 9) begin
      errors++;
      $display("FAIL s7_latency: got %0d, want 9", lat7);
    end
    @(posedge clk); #1;
    // Each (x,y) pair goes to one instance in each mode.
    for (int cyc = 0; cyc < 65536 + 16; cyc++) begin
      sw_valid = (cyc < 65536);
      sw_x = cyc[15:8];
      sw_y = cyc[7:0];
      m = cyc[0] ^ cyc[8];
      sw0_signed = m;
      sw7_signed = ~m;
      @(negedge clk);
      if (s0_out_valid === 1'b1) begin
        checks++;
        if (q0.size() == 0 || {s0_out_signed, s0_out_p} !== q0[0]) begin
          errors++;
          $display("FAIL s0_product: got %h, want %h", {s0_out_signed, s0_out_p}, (q0.size() == 0) ? 17'h0 : q0[0]);
        end
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (s7_out_valid === 1'b1) begin
        checks++;
        if (q7.size() == 0 || {s7_out_signed, s7_out_p} !== q7[0]) begin
          errors++;
          $display("FAIL s7_product: got %h, want %h", {s7_out_signed, s7_out_p}, (q7.size() == 0) ? 17'h0 : q7[0]);
        end
        if (q7.size() != 0) void'(q7.pop_front());
      end
      if (sw_valid && s0_in_ready === 1'b1) q0.push_back({sw0_signed, gold(sw_x, sw_y, sw0_signed)});
      if (sw_valid && s7_in_ready === 1'b1) q7.push_back({sw7_signed, gold(sw_x, sw_y, sw7_signed)});
      @(posedge clk); #1;
    end
    checks++;
    if (q0.size() != 0 || q7.size() != 0) begin
      errors++;
      $display("FAIL sweep_drain: got %0d/%0d pending, want 0/0", q0.size(), q7.size());
    end
  endtask

  initial begin
    test_reset();
    test_most_negative();
    test_back_to_back();
    test_random_stream();
    test_backpressure();
    test_reset_midflight();
    test_stage_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
